// File: rtl/tt_um_hamming_encoder_74.sv
// Hamming(7,4) encoder with a serial LSB-first transmitter and a 1-entry holding register.
// Latency: accept edge -> c0 on serial_out one clock later; each frame takes 7 enabled cycles.
// Backpressure: data_ready drops while the holding register is full; ena=0 freezes all state.
module tt_um_hamming_encoder_74 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       serial_out,
    output logic       tx_active,
    output logic       frame_start,
    output logic       frame_done,
    output logic [2:0] bit_index,
    output logic [2:0] parity_out
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] shift_q, shift_d;
    logic [6:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] par_q, par_d;
    logic       done_q, done_d;

    logic       p1, p2, p3;
    logic [6:0] enc_cw;
    logic       accept;
    logic       last_bit;

    // Codeword for the offered nibble; Hamming positions 1..7 map to c0..c6.
    assign p1     = data_in[0] ^ data_in[1] ^ data_in[3];
    assign p2     = data_in[0] ^ data_in[2] ^ data_in[3];
    assign p3     = data_in[1] ^ data_in[2] ^ data_in[3];
    assign enc_cw = {data_in[3], data_in[2], data_in[1], p3, data_in[0], p2, p1};

    assign accept   = ena & data_valid & ~hold_full_q;
    assign last_bit = (state_q == SEND) && (idx_q == 3'd6);

    // Next-state logic: load, shift, hold-register handoff and return to idle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idx_d       = idx_q;
        par_d       = par_q;
        done_d      = 1'b0;
        if (ena) begin
            done_d = last_bit;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = SEND;
                        shift_d = enc_cw;
                        par_d   = {p3, p2, p1};
                        idx_d   = 3'd0;
                    end
                end
                SEND: begin
                    if (idx_q != 3'd6) begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[6:1]};
                        if (accept) begin
                            hold_d      = enc_cw;
                            hold_full_d = 1'b1;
                        end
                    end else if (hold_full_q) begin
                        // Held frame follows with no idle gap.
                        shift_d     = hold_q;
                        par_d       = {hold_q[3], hold_q[1], hold_q[0]};
                        hold_full_d = 1'b0;
                        idx_d       = 3'd0;
                    end else if (accept) begin
                        // Empty holding register: new codeword goes straight to the shifter.
                        shift_d = enc_cw;
                        par_d   = {p3, p2, p1};
                        idx_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                        shift_d = 7'd0;
                        idx_d   = 3'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers; reset aborts any frame in flight and empties the holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= 7'd0;
            hold_q      <= 7'd0;
            hold_full_q <= 1'b0;
            idx_q       <= 3'd0;
            par_q       <= 3'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            done_q      <= done_d;
        end
    end

    assign data_ready  = ~hold_full_q;
    assign tx_active   = (state_q == SEND);
    assign serial_out  = tx_active & shift_q[0];
    assign frame_start = tx_active && (idx_q == 3'd0);
    assign bit_index   = tx_active ? idx_q : 3'd0;
    assign parity_out  = par_q;
    assign frame_done  = done_q;

endmodule

// File: tb/tb_tt_um_hamming_encoder_74.sv
// Scoreboard bench for the Hamming(7,4) serial encoder.
// Stimulus pushes expected codewords on accept; a negedge monitor pops and compares each frame.
// The monitor also decodes every received frame with an independent syndrome receiver.
module tb_tt_um_hamming_encoder_74;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       serial_out;
    logic       tx_active;
    logic       frame_start;
    logic       frame_done;
    logic [2:0] bit_index;
    logic [2:0] parity_out;

    tt_um_hamming_encoder_74 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .serial_out (serial_out),
        .tx_active  (tx_active),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .bit_index  (bit_index),
        .parity_out (parity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed codewords c[6:0] for nibbles 0..15.
    logic [6:0] cw_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    logic [10:0] exp_q [$];   // {nibble, codeword}

    int n_checks = 0;
    int n_pass   = 0;
    int n_decoded = 0;
    int n_fd      = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Offer a nibble; junk is driven on data_in while data_ready is low.
    task automatic send(input logic [3:0] n);
        bit done = 0;
        data_valid = 1'b1;
        for (int w = 0; w < 60 && !done; w++) begin
            if (data_ready && ena) begin
                data_in = n;
                @(posedge clk);
                exp_q.push_back({n, cw_tab[n]});
                done = 1;
                #1;
            end else begin
                data_in = ~n;
                @(posedge clk);
                #1;
            end
        end
        data_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    task automatic wait_idx(input logic [2:0] k);
        bit hit = 0;
        for (int w = 0; w < 60 && !hit; w++) begin
            if (tx_active && bit_index == k) hit = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!hit) fail_now("wait_idx_timeout");
    endtask

    task automatic drain();
        bit idle = 0;
        for (int w = 0; w < 300 && !idle; w++) begin
            if (!tx_active && exp_q.size() == 0) idle = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!idle) fail_now("drain_timeout");
    endtask

    // Monitor state
    logic       prev_tx, prev_ena, prev_ser;
    logic [2:0] prev_idx;
    logic [6:0] cur_cw;
    logic [3:0] cur_nib;
    logic [6:0] rx;
    int         exp_idx;

    // Monitor: sample away from the active edge and check every presented bit.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_tx  = 1'b0;
            prev_ena = 1'b0;
            prev_ser = 1'b0;
            prev_idx = 3'd0;
            exp_idx  = 0;
        end else begin
            chk("frame_done", frame_done, (prev_tx && prev_ena && prev_idx == 3'd6));
            if (frame_done) n_fd++;
            if (prev_tx && !prev_ena) begin
                chk("hold_tx_active", tx_active, 1'b1);
                chk("hold_serial", serial_out, prev_ser);
                chk("hold_bit_index", bit_index, prev_idx);
            end else if (tx_active) begin
                if (exp_idx == 0) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_frame");
                        cur_cw  = 7'd0;
                        cur_nib = 4'd0;
                    end else begin
                        {cur_nib, cur_cw} = exp_q.pop_front();
                        chk("parity_out", parity_out, {cur_cw[3], cur_cw[1], cur_cw[0]});
                    end
                end
                chk("bit_index", bit_index, exp_idx[2:0]);
                chk("frame_start", frame_start, (exp_idx == 0));
                chk("serial_out", serial_out, cur_cw[exp_idx[2:0]]);
                rx[exp_idx[2:0]] = serial_out;
                if (exp_idx == 6) begin
                    chk("rx_syndrome",
                        {rx[3] ^ rx[4] ^ rx[5] ^ rx[6], rx[1] ^ rx[2] ^ rx[5] ^ rx[6],
                         rx[0] ^ rx[2] ^ rx[4] ^ rx[6]}, 3'b000);
                    chk("rx_nibble", {rx[6], rx[5], rx[4], rx[2]}, cur_nib);
                    n_decoded++;
                    exp_idx = 0;
                end else begin
                    exp_idx++;
                end
            end else begin
                chk("tx_gap", exp_idx[7:0], 8'd0);
                chk("idle_outputs", {serial_out, frame_start, bit_index}, 5'd0);
            end
            prev_tx  = tx_active;
            prev_ena = ena;
            prev_ser = serial_out;
            prev_idx = bit_index;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        data_in    = 4'd0;
        data_valid = 1'b0;
        #2;
        chk("rst_data_ready", data_ready, 1'b1);
        chk("rst_tx_active", tx_active, 1'b0);
        chk("rst_serial", serial_out, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_bit_index", bit_index, 3'd0);
        chk("rst_parity", parity_out, 3'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First edge after release accepts; 1011 -> 1,0,1,0,1,0,1 with parity 001.
        send(4'b1011);
        chk("parity_1011", parity_out, 3'b001);
        begin
            int c;
            c = 0;
            for (int w = 1; w <= 12 && c == 0; w++) begin
                @(posedge clk);
                #1;
                if (frame_done) c = w;
            end
            chk("fd_edges_after_accept", c[7:0], 8'd7);
        end
        drain();

        send(4'b0001);
        drain();
        send(4'b1111);
        send(4'b0000);
        drain();

        // Three nibbles with valid held high: 21 contiguous bits.
        send(4'h3);
        chk("ready_after_first", data_ready, 1'b1);
        fork
            begin
                send(4'hA);
                chk("ready_after_second", data_ready, 1'b0);
                send(4'h6);
            end
            begin
                for (int k = 0; k < 21; k++) begin
                    chk("burst_tx_active", tx_active, 1'b1);
                    chk("burst_frame_start", frame_start, (k % 7 == 0));
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();

        // Bypass straight into the shifter on the final-bit edge.
        send(4'h5);
        wait_idx(3'd6);
        send(4'hC);
        drain();

        // ena low for 5 cycles at bit 3.
        send(4'h9);
        wait_idx(3'd3);
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
        drain();

        // Reset at bit 4 with the holding register full.
        send(4'hE);
        send(4'h2);
        chk("hold_full_ready", data_ready, 1'b0);
        wait_idx(3'd4);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_ready", data_ready, 1'b1);
        chk("midrst_tx_active", tx_active, 1'b0);
        chk("midrst_serial", serial_out, 1'b0);
        chk("midrst_bit_index", bit_index, 3'd0);
        chk("midrst_frame_start", frame_start, 1'b0);
        chk("midrst_parity", parity_out, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("post_rst_ready", data_ready, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // All 16 nibbles back to back through the receiver.
        for (int n = 0; n < 16; n++) send(n[3:0]);
        drain();
        repeat (3) @(posedge clk);
        #1;

        chk("frames_decoded", n_decoded[7:0], 8'd26);
        chk("frame_done_count", n_fd[7:0], 8'd26);
        chk("queue_empty", exp_q.size(), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
